// File: rtl/gtfwizard_mac_buffbypass_tx_ctrl.sv
// TX buffer-bypass supervisory sequencer.
// Starts, qualifies, retries and re-arms the auto-mode bypass block.
module gtfwizard_mac_buffbypass_tx_ctrl #(
  parameter int P_TIMEOUT_CYCLES = 20000,
  parameter int P_MAX_RETRIES    = 3,
  parameter int P_SETTLE_CYCLES  = 64,
  parameter int P_BACKOFF_CYCLES = 256
) (
  input  logic       gtwiz_buffbypass_tx_clk_in,
  input  logic       gtwiz_buffbypass_tx_reset_in,
  input  logic       tx_resetdone_in,
  input  logic       restart_in,
  input  logic       bypass_done_in,
  input  logic       bypass_error_in,
  input  logic       phaligndone_in,
  output logic       bypass_reset_out,
  output logic       bypass_start_out,
  output logic       tx_ready_out,
  output logic       tx_fail_out,
  output logic [3:0] retry_count_out,
  output logic [7:0] lock_loss_count_out,
  output logic [2:0] state_out
);

  typedef enum logic [2:0] {
    S_WAIT_RSTDONE = 3'd0,
    S_START        = 3'd1,
    S_WAIT_DONE    = 3'd2,
    S_SETTLE       = 3'd3,
    S_LOCKED       = 3'd4,
    S_BACKOFF      = 3'd5,
    S_FAIL         = 3'd6
  } state_e;

  localparam logic [15:0] TO_LAST =
    16'(P_TIMEOUT_CYCLES - 1);
  localparam logic [15:0] ST_LAST =
    16'(P_SETTLE_CYCLES - 1);
  localparam logic [15:0] BO_LAST =
    16'(P_BACKOFF_CYCLES - 1);
  localparam logic [3:0]  MAX_RTY =
    4'(P_MAX_RETRIES);

  logic        clk;
  logic        rst;

  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [3:0]  retry_q, retry_d;
  logic [7:0]  ll_q, ll_d;
  logic        low_q, low_d;
  logic        brst_q, brst_d;
  logic        start_q, start_d;
  logic        ready_q, ready_d;
  logic        fail_q, fail_d;
  logic        att_fail;
  logic        rd_active;

  assign clk = gtwiz_buffbypass_tx_clk_in;
  assign rst = gtwiz_buffbypass_tx_reset_in;

  // Next-state, counters and registered output values.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    retry_d   = retry_q;
    ll_d      = ll_q;
    low_d     = 1'b0;
    att_fail  = 1'b0;
    rd_active = 1'b0;

    unique case (state_q)
      S_WAIT_RSTDONE: begin
        if (tx_resetdone_in)
          state_d = S_START;
      end
      S_START: begin
        rd_active = 1'b1;
        state_d   = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        rd_active = 1'b1;
        timer_d   = timer_q + 16'd1;
        if (bypass_done_in && !bypass_error_in)
          state_d = S_SETTLE;
        else if (bypass_done_in)
          att_fail = 1'b1;
        else if (timer_q == TO_LAST)
          att_fail = 1'b1;
      end
      S_SETTLE: begin
        rd_active = 1'b1;
        timer_d   = timer_q + 16'd1;
        if (!phaligndone_in)
          att_fail = 1'b1;
        else if (timer_q == ST_LAST)
          state_d = S_LOCKED;
      end
      S_LOCKED: begin
        rd_active = 1'b1;
        if (!phaligndone_in && low_q) begin
          state_d = S_BACKOFF;
          if (ll_q != 8'hFF)
            ll_d = ll_q + 8'd1;
        end else begin
          low_d = !phaligndone_in;
        end
      end
      S_BACKOFF: begin
        timer_d = timer_q + 16'd1;
        if (timer_q == BO_LAST)
          state_d = S_WAIT_RSTDONE;
      end
      S_FAIL: begin
        state_d = S_FAIL;
      end
      default: begin
        state_d = S_WAIT_RSTDONE;
      end
    endcase

    if (att_fail) begin
      if (retry_q == MAX_RTY) begin
        state_d = S_FAIL;
      end else begin
        retry_d = retry_q + 4'd1;
        state_d = S_BACKOFF;
      end
    end

    if (restart_in) begin
      state_d = S_BACKOFF;
      retry_d = 4'd0;
      ll_d    = ll_q;
      low_d   = 1'b0;
    end else if (!tx_resetdone_in && rd_active) begin
      state_d = S_WAIT_RSTDONE;
      retry_d = retry_q;
      ll_d    = ll_q;
      low_d   = 1'b0;
    end

    if (state_d != state_q || restart_in)
      timer_d = 16'd0;

    if (state_d == S_LOCKED)
      retry_d = 4'd0;

    brst_d  = (state_d == S_WAIT_RSTDONE) ||
              (state_d == S_BACKOFF) ||
              (state_d == S_FAIL);
    start_d = (state_d == S_START);
    ready_d = (state_d == S_LOCKED);
    fail_d  = (state_d == S_FAIL);
  end

  // State, counters and outputs, all synchronously reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_WAIT_RSTDONE;
      timer_q <= 16'd0;
      retry_q <= 4'd0;
      ll_q    <= 8'd0;
      low_q   <= 1'b0;
      brst_q  <= 1'b1;
      start_q <= 1'b0;
      ready_q <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      ll_q    <= ll_d;
      low_q   <= low_d;
      brst_q  <= brst_d;
      start_q <= start_d;
      ready_q <= ready_d;
      fail_q  <= fail_d;
    end
  end

  assign bypass_reset_out    = brst_q;
  assign bypass_start_out    = start_q;
  assign tx_ready_out        = ready_q;
  assign tx_fail_out         = fail_q;
  assign retry_count_out     = retry_q;
  assign lock_loss_count_out = ll_q;
  assign state_out           = state_q;

endmodule

// File: tb/tb_gtfwizard_mac_buffbypass_tx_ctrl.sv
// Bench for the TX buffer-bypass sequencer.
// Directed scenarios plus random traffic against a deadline-based model.
module tb_gtfwizard_mac_buffbypass_tx_ctrl;

  localparam int TO = 100;
  localparam int MR = 3;
  localparam int SC = 64;
  localparam int BO = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rd, rs, dn, er, ph;
  logic       brst_o, start_o, ready_o, fail_o;
  logic [3:0] retry_o;
  logic [7:0] ll_o;
  logic [2:0] state_o;

  gtfwizard_mac_buffbypass_tx_ctrl #(
    .P_TIMEOUT_CYCLES(TO),
    .P_MAX_RETRIES(MR),
    .P_SETTLE_CYCLES(SC),
    .P_BACKOFF_CYCLES(BO)
  ) dut (
    .gtwiz_buffbypass_tx_clk_in(clk),
    .gtwiz_buffbypass_tx_reset_in(rst),
    .tx_resetdone_in(rd),
    .restart_in(rs),
    .bypass_done_in(dn),
    .bypass_error_in(er),
    .phaligndone_in(ph),
    .bypass_reset_out(brst_o),
    .bypass_start_out(start_o),
    .tx_ready_out(ready_o),
    .tx_fail_out(fail_o),
    .retry_count_out(retry_o),
    .lock_loss_count_out(ll_o),
    .state_out(state_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_start = 0;

  // Model: phase id, absolute deadline cycle, counters.
  int m_st, m_retry, m_ll, m_dl;
  bit m_low;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d",
               tag, cyc, got, exp);
    end
  endtask

  function automatic int seg_len(input int s);
    case (s)
      2: return TO;
      3: return SC;
      5: return BO;
      default: return 0;
    endcase
  endfunction

  // Entering a phase at the cycle after 'now'.
  task automatic m_enter(input int s, input int now);
    m_st  = s;
    m_low = 0;
    m_dl  = now + seg_len(s);
    if (s == 4) m_retry = 0;
  endtask

  task automatic m_fail(input int now);
    if (m_retry == MR) m_enter(6, now);
    else begin
      m_retry++;
      m_enter(5, now);
    end
  endtask

  task automatic m_step(input int now);
    if (rst) begin
      m_st = 0; m_retry = 0; m_ll = 0;
      m_low = 0; m_dl = 0;
    end else if (rs) begin
      m_retry = 0;
      m_enter(5, now);
    end else if (!rd && m_st >= 1 && m_st <= 4) begin
      m_enter(0, now);
    end else begin
      case (m_st)
        0: if (rd) m_enter(1, now);
        1: m_enter(2, now);
        2: begin
          if (dn && !er) m_enter(3, now);
          else if (dn || now == m_dl) m_fail(now);
        end
        3: begin
          if (!ph) m_fail(now);
          else if (now == m_dl) m_enter(4, now);
        end
        4: begin
          if (!ph && m_low) begin
            if (m_ll < 255) m_ll++;
            m_enter(5, now);
          end else m_low = !ph;
        end
        5: if (now == m_dl) m_enter(0, now);
        default: ;
      endcase
    end
  endtask

  task automatic tick(input bit r, input bit s,
                      input bit d, input bit dd,
                      input bit e, input bit p);
    rst = r; rs = s; rd = d;
    dn = dd; er = e; ph = p;
    m_step(cyc);
    @(negedge clk);
    cyc++;
    if (start_o === 1'b1) n_start++;
    chk("state", 32'(state_o), m_st);
    chk("byp_rst", 32'(brst_o),
        (m_st == 0 || m_st == 5 || m_st == 6) ? 1 : 0);
    chk("start", 32'(start_o), (m_st == 1) ? 1 : 0);
    chk("ready", 32'(ready_o), (m_st == 4) ? 1 : 0);
    chk("fail", 32'(fail_o), (m_st == 6) ? 1 : 0);
    chk("retry", 32'(retry_o), m_retry);
    chk("lockloss", 32'(ll_o), m_ll);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 1, 0, 0, 1);
  endtask

  task automatic wait_start();
    for (int i = 0; i < 2000; i++) begin
      if (start_o === 1'b1) return;
      idle(1);
    end
    chk("start_timeout", 0, 1);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 2000; i++) begin
      if (ready_o === 1'b1) return;
      idle(1);
    end
    chk("ready_timeout", 0, 1);
  endtask

  // Called on the cycle a start pulse is visible.
  task automatic attempt(input int dly, input bit err);
    idle(dly);
    tick(0, 0, 1, 1, err, 1);
  endtask

  int s0, n0, f0, rise;
  int resp_at;
  bit resp_err;
  bit rd_v;

  initial begin
    rst = 1; rs = 0; rd = 0;
    dn = 0; er = 0; ph = 1;

    tick(1, 0, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 0, 1);
    chk("rst_state", 32'(state_o), 0);
    chk("rst_byp", 32'(brst_o), 1);

    // Nominal bring-up.
    n0 = n_start;
    wait_start();
    s0 = cyc;
    attempt(10, 0);
    rise = -1;
    for (int i = 0; i < 200 && rise < 0; i++) begin
      if (ready_o === 1'b1) rise = cyc;
      else idle(1);
    end
    chk("nom_lat", rise - s0, 10 + SC + 1);
    chk("nom_starts", n_start - n0, 1);
    chk("nom_retry", 32'(retry_o), 0);

    // Two error attempts, then a clean one.
    tick(0, 1, 1, 0, 0, 1);
    n0 = n_start;
    wait_start();
    attempt(5, 1);
    f0 = cyc - 1;
    wait_start();
    chk("bo_gap", cyc - f0, BO + 2);
    attempt(5, 1);
    wait_start();
    attempt(5, 0);
    idle(2);
    chk("retry_settle", 32'(retry_o), 2);
    wait_ready();
    chk("retry_locked", 32'(retry_o), 0);
    chk("err_starts", n_start - n0, 3);

    // Timeouts until retries are exhausted.
    tick(0, 1, 1, 0, 0, 1);
    n0 = n_start;
    for (int k = 0; k < MR + 1; k++) begin
      wait_start();
      idle(TO + 2);
    end
    chk("exh_fail", 32'(fail_o), 1);
    chk("exh_state", 32'(state_o), 6);
    idle(100);
    chk("exh_starts", n_start - n0, MR + 1);
    tick(0, 1, 1, 0, 0, 1);
    chk("rs_fail", 32'(fail_o), 0);
    chk("rs_retry", 32'(retry_o), 0);
    chk("rs_state", 32'(state_o), 5);
    wait_start();
    chk("rs_newseq", n_start - n0, MR + 2);

    // Settle break at settle cycle 30.
    attempt(4, 0);
    idle(30);
    tick(0, 0, 1, 0, 0, 0);
    chk("brk_retry", 32'(retry_o), 1);
    chk("brk_state", 32'(state_o), 5);

    // Done on the timeout cycle wins.
    wait_start();
    idle(TO);
    tick(0, 0, 1, 1, 0, 1);
    chk("dn_to_state", 32'(state_o), 3);

    // Restart beats resetdone loss.
    tick(0, 1, 0, 0, 0, 1);
    chk("rs_vs_rd", 32'(state_o), 5);

    // Lock loss, glitch immunity and saturation.
    wait_start();
    attempt(3, 0);
    wait_ready();
    tick(0, 0, 1, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 1);
    chk("glitch_ready", 32'(ready_o), 1);
    tick(0, 0, 1, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0);
    chk("loss_ready", 32'(ready_o), 0);
    chk("loss_cnt", 32'(ll_o), 1);
    chk("loss_state", 32'(state_o), 5);
    for (int k = 0; k < 299; k++) begin
      wait_start();
      attempt(2, 0);
      wait_ready();
      tick(0, 0, 1, 0, 0, 0);
      tick(0, 0, 1, 0, 0, 0);
    end
    chk("ll_sat", 32'(ll_o), 255);

    // Reset while waiting for done.
    wait_start();
    idle(3);
    tick(1, 0, 1, 0, 0, 1);
    chk("mid_state", 32'(state_o), 0);
    chk("mid_byp", 32'(brst_o), 1);
    chk("mid_retry", 32'(retry_o), 0);
    chk("mid_ll", 32'(ll_o), 0);

    // Random traffic with a responding bypass block.
    resp_at = -1;
    resp_err = 0;
    rd_v = 1;
    for (int i = 0; i < 20000; i++) begin
      bit r_r, r_s, r_d, r_e, r_p;
      if (start_o === 1'b1) begin
        resp_at  = cyc + int'($urandom_range(1, TO + 10));
        resp_err = ($urandom_range(0, 3) == 0);
      end
      if (rd_v) rd_v = ($urandom_range(0, 299) != 0);
      else      rd_v = ($urandom_range(0, 3) == 0);
      r_r = ($urandom_range(0, 2999) == 0);
      r_s = ($urandom_range(0, 799) == 0);
      r_d = (cyc == resp_at) ||
            ($urandom_range(0, 199) == 0);
      r_e = (cyc == resp_at) ? resp_err
                             : 1'($urandom_range(0, 1));
      r_p = ($urandom_range(0, 149) != 0);
      tick(r_r, r_s, rd_v, r_d, r_e, r_p);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
